// File: rtl/super_reu_pkg.sv
// Shared Super-REU definitions: default HyperRAM bus widths used by the DMA engine,
// MMC64 and the arbitrator, plus the write-buffer drain-state encoding.
package super_reu_pkg;

  localparam int HRAM_ABITS = 24;
  localparam int HRAM_DBITS = 8;

  typedef enum logic [1:0] {
    DRAIN_IDLE = 2'd0,
    DRAIN_WR   = 2'd1,
    DRAIN_RD   = 2'd2
  } drain_state_t;

endpackage

// File: rtl/hram_wbuf_fifo.sv
// Entry storage, pointers and fill level for the HyperRAM posted-write buffer.
// With HRAM_WBUF_RAW_FWD_EN defined it also exposes every entry and a valid mask.
module hram_wbuf_fifo
  import super_reu_pkg::*;
#(
  parameter int ABITS = HRAM_ABITS,
  parameter int DBITS = HRAM_DBITS,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  logic [ABITS-1:0]         i_pushA,
  input  logic [DBITS-1:0]         i_pushD,
  input  logic                     i_pop,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [ABITS-1:0]         o_headA,
  output logic [DBITS-1:0]         o_headD,
  output logic [$clog2(DEPTH):0]   o_level
`ifdef HRAM_WBUF_RAW_FWD_EN
  ,
  output logic [DEPTH-1:0][ABITS-1:0] o_entA,
  output logic [DEPTH-1:0][DBITS-1:0] o_entD,
  output logic [DEPTH-1:0]            o_valid,
  output logic [$clog2(DEPTH)-1:0]    o_rdPtr
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [ABITS-1:0] r_memA [DEPTH];
  logic [DBITS-1:0] r_memD [DEPTH];
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [LW-1:0]    r_level;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (i_push) r_wrPtr <= r_wrPtr + PW'(1);
      if (i_pop)  r_rdPtr <= r_rdPtr + PW'(1);
      if (i_push && !i_pop)
        r_level <= r_level + LW'(1);
      else if (!i_push && i_pop)
        r_level <= r_level - LW'(1);
    end
  end

  // Payload needs no reset; only the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_memA[r_wrPtr] <= i_pushA;
      r_memD[r_wrPtr] <= i_pushD;
    end
  end

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_headA = r_memA[r_rdPtr];
  assign o_headD = r_memD[r_rdPtr];
  assign o_level = r_level;

`ifdef HRAM_WBUF_RAW_FWD_EN
  for (genvar g = 0; g < DEPTH; g++) begin : g_fwd
    logic [PW-1:0] w_age;
    assign w_age      = PW'(g) - r_rdPtr;
    assign o_entA[g]  = r_memA[g];
    assign o_entD[g]  = r_memD[g];
    assign o_valid[g] = ({1'b0, w_age} < r_level);
  end
  assign o_rdPtr = r_rdPtr;
`endif

endmodule

// File: rtl/hram_write_buffer.sv
// Posted-write buffer between the DMA HyperRAM master port and the memory arbitrator.
// Define HRAM_WBUF_RAW_FWD_EN to answer reads that hit a queued write from the buffer.
module hram_write_buffer
  import super_reu_pkg::*;
#(
  parameter int ABITS = HRAM_ABITS,
  parameter int DBITS = HRAM_DBITS,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   m_req,
  output logic                   m_ack,
  input  logic                   m_we,
  input  logic [ABITS-1:0]       m_a,
  input  logic [DBITS-1:0]       m_d,
  output logic [DBITS-1:0]       m_q,
  output logic                   s_req,
  input  logic                   s_ack,
  output logic                   s_we,
  output logic [ABITS-1:0]       s_a,
  output logic [DBITS-1:0]       s_d,
  input  logic [DBITS-1:0]       s_q,
  output logic [$clog2(DEPTH):0] level,
  output logic                   idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  drain_state_t     r_state;
  drain_state_t     w_stateNext;
  logic             r_mAck, r_sReq, r_sWe, r_idle;
  logic [DBITS-1:0] r_mQ, r_sD;
  logic [ABITS-1:0] r_sA;

  logic             w_newReq, w_push, w_pop, w_rdReq, w_fwdAck, w_idleNext;
  logic             w_full, w_empty, w_fwdHit;
  logic [ABITS-1:0] w_headA;
  logic [DBITS-1:0] w_headD, w_fwdData;
  logic [LW-1:0]    w_level, w_levelNext;

`ifdef HRAM_WBUF_RAW_FWD_EN
  logic [DEPTH-1:0][ABITS-1:0] w_entA;
  logic [DEPTH-1:0][DBITS-1:0] w_entD;
  logic [DEPTH-1:0]            w_valid;
  logic [PW-1:0]               w_rdPtr;
  logic [PW-1:0]               w_idx;

  // Walk from oldest to newest so the last hit leaves the most recent data.
  always_comb begin
    w_fwdHit  = 1'b0;
    w_fwdData = '0;
    w_idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = w_rdPtr + PW'(k);
      if (w_valid[w_idx] && (w_entA[w_idx] == m_a)) begin
        w_fwdHit  = 1'b1;
        w_fwdData = w_entD[w_idx];
      end
    end
  end
`else
  assign w_fwdHit  = 1'b0;
  assign w_fwdData = '0;
`endif

  hram_wbuf_fifo #(
    .ABITS(ABITS),
    .DBITS(DBITS),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_pushA (m_a),
    .i_pushD (m_d),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_headA (w_headA),
    .o_headD (w_headD),
    .o_level (w_level)
`ifdef HRAM_WBUF_RAW_FWD_EN
    ,
    .o_entA  (w_entA),
    .o_entD  (w_entD),
    .o_valid (w_valid),
    .o_rdPtr (w_rdPtr)
`endif
  );

  // A held request is only seen again once the previous ack pulse has gone.
  always_comb begin
    w_newReq    = m_req && !r_mAck;
    w_push      = w_newReq && m_we && !w_full;
    w_fwdAck    = w_newReq && !m_we && w_fwdHit;
    w_rdReq     = w_newReq && !m_we && !w_fwdHit;
    w_pop       = (r_state == DRAIN_WR) && s_ack;
    w_stateNext = r_state;
    case (r_state)
      DRAIN_IDLE: begin
        if (!w_empty)     w_stateNext = DRAIN_WR;
        else if (w_rdReq) w_stateNext = DRAIN_RD;
      end
      DRAIN_WR, DRAIN_RD: if (s_ack) w_stateNext = DRAIN_IDLE;
      default:            w_stateNext = DRAIN_IDLE;
    endcase
    w_levelNext = w_level + LW'(w_push) - LW'(w_pop);
    w_idleNext  = (w_levelNext == '0) && (w_stateNext == DRAIN_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= DRAIN_IDLE;
      r_mAck  <= 1'b0;
      r_mQ    <= '0;
      r_sReq  <= 1'b0;
      r_sWe   <= 1'b0;
      r_sA    <= '0;
      r_sD    <= '0;
      r_idle  <= 1'b1;
    end else begin
      r_state <= w_stateNext;
      r_idle  <= w_idleNext;
      r_mAck  <= w_push || w_fwdAck;
      if (w_fwdAck) r_mQ <= w_fwdData;
      case (r_state)
        DRAIN_IDLE: begin
          if (w_stateNext == DRAIN_WR) begin
            r_sReq <= 1'b1;
            r_sWe  <= 1'b1;
            r_sA   <= w_headA;
            r_sD   <= w_headD;
          end else if (w_stateNext == DRAIN_RD) begin
            r_sReq <= 1'b1;
            r_sWe  <= 1'b0;
            r_sA   <= m_a;
          end
        end
        DRAIN_WR: if (s_ack) r_sReq <= 1'b0;
        DRAIN_RD: begin
          if (s_ack) begin
            r_sReq <= 1'b0;
            r_mQ   <= s_q;
            r_mAck <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_ack = r_mAck;
  assign m_q   = r_mQ;
  assign s_req = r_sReq;
  assign s_we  = r_sWe;
  assign s_a   = r_sA;
  assign s_d   = r_sD;
  assign level = w_level;
  assign idle  = r_idle;

endmodule

// File: tb/tb_hram_write_buffer.sv
// Directed bench for hram_write_buffer: reset, burst to full, ordering across wrap,
// read-after-write (or forwarding when HRAM_WBUF_RAW_FWD_EN is defined), no double accept.
module tb_hram_write_buffer;

  localparam int ABITS = 24;
  localparam int DBITS = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             m_req, m_we, s_ack;
  logic [ABITS-1:0] m_a;
  logic [DBITS-1:0] m_d, s_q;
  logic             m_ack, s_req, s_we, idle;
  logic [DBITS-1:0] m_q, s_d;
  logic [ABITS-1:0] s_a;
  logic [2:0]       level;

  int total = 0;
  int bad   = 0;

  bit respEn     = 1'b0;
  bit respRandom = 1'b0;
  bit busy       = 1'b0;
  int waitCnt    = 0;

  logic             q_we  [$];
  logic [ABITS-1:0] q_a   [$];
  logic [DBITS-1:0] q_d   [$];
  logic [2:0]       q_lvl [$];

  hram_write_buffer #(.ABITS(ABITS), .DBITS(DBITS), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .m_req(m_req), .m_ack(m_ack), .m_we(m_we), .m_a(m_a), .m_d(m_d), .m_q(m_q),
    .s_req(s_req), .s_ack(s_ack), .s_we(s_we), .s_a(s_a), .s_d(s_d), .s_q(s_q),
    .level(level), .idle(idle)
  );

  always #5 clk = ~clk;

  // Arbitrator model: acks each s_req after 1..5 cycles and logs what it committed.
  initial begin
    s_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!reset_n) begin
        s_ack = 1'b0;
        busy  = 1'b0;
      end else if (s_ack) begin
        s_ack = 1'b0;
      end else if (respEn && s_req) begin
        if (!busy) begin
          busy    = 1'b1;
          waitCnt = respRandom ? int'($urandom_range(0, 4)) : 0;
        end
        if (waitCnt == 0) begin
          s_ack = 1'b1;
          busy  = 1'b0;
          q_we.push_back(s_we);
          q_a.push_back(s_a);
          q_d.push_back(s_d);
          q_lvl.push_back(level);
        end else begin
          waitCnt--;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkLog(input string tag, input int idx, input logic [ABITS-1:0] a,
                          input logic [DBITS-1:0] d);
    logic [63:0] obs;
    obs = 64'hDEAD_0000_0000_0000;
    if (idx < q_a.size()) obs = {31'd0, q_we[idx], q_a[idx], q_d[idx]};
    checkOutput(tag, obs, {31'd0, 1'b1, a, d});
  endtask

  task automatic clearLog();
    q_we.delete();
    q_a.delete();
    q_d.delete();
    q_lvl.delete();
  endtask

  task automatic waitAck(input int maxCycles, output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < maxCycles) begin
      @(negedge clk);
      lat++;
      if (m_ack) seen = 1'b1;
    end
    checkOutput("ack_seen", 64'(seen), 64'd1);
  endtask

  task automatic applyStimulus(input logic we, input logic [ABITS-1:0] a, input logic [DBITS-1:0] d,
                               input int maxCycles, output int lat, output logic [DBITS-1:0] q);
    @(negedge clk);
    m_req = 1'b1;
    m_we  = we;
    m_a   = a;
    m_d   = d;
    waitAck(maxCycles, lat);
    q     = m_q;
    m_req = 1'b0;
  endtask

  task automatic waitIdle(input int maxCycles);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!idle && n < maxCycles);
    checkOutput("idle_reached", 64'(idle), 64'd1);
  endtask

  initial begin
    int               lat, n;
    bit               seen;
    logic [DBITS-1:0] q;

    reset_n = 1'b0;
    m_req   = 1'b0;
    m_we    = 1'b0;
    m_a     = '0;
    m_d     = '0;
    s_q     = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_m_ack", 64'(m_ack), 64'd0);
    checkOutput("rst_m_q",   64'(m_q),   64'd0);
    checkOutput("rst_s_req", 64'(s_req), 64'd0);
    checkOutput("rst_s_we",  64'(s_we),  64'd0);
    checkOutput("rst_s_a",   64'(s_a),   64'd0);
    checkOutput("rst_s_d",   64'(s_d),   64'd0);
    checkOutput("rst_level", 64'(level), 64'd0);
    checkOutput("rst_idle",  64'(idle),  64'd1);
    reset_n = 1'b1;

    // Burst to full with the arbitrator stalled
    $display("[TB] burst to full");
    respEn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 24'(32'h10 + i), 8'(32'h11 + i), 5, lat, q);
      checkOutput($sformatf("burst_lat%0d", i), 64'(lat), 64'd1);
    end
    checkOutput("burst_level", 64'(level), 64'd4);
    checkOutput("burst_head", {31'd0, s_req, s_we, s_a, s_d}, {31'd0, 1'b1, 1'b1, 24'h000010, 8'h11});

    @(negedge clk);
    m_req = 1'b1;
    m_we  = 1'b1;
    m_a   = 24'h000014;
    m_d   = 8'h15;
    seen  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (m_ack) seen = 1'b1;
    end
    checkOutput("full_stall", 64'(seen), 64'd0);
    clearLog();
    respRandom = 1'b0;
    respEn     = 1'b1;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      if (n == 2) begin
        checkOutput("full_pop_level", 64'(level), 64'd3);
        checkOutput("full_pop_noack", 64'(m_ack), 64'd0);
      end
      if (m_ack) seen = 1'b1;
    end
    m_req = 1'b0;
    checkOutput("full_ack_delay", 64'(n), 64'd3);
    checkOutput("full_ack_level", 64'(level), 64'd4);
    respRandom = 1'b1;
    waitIdle(200);
    checkOutput("burst_drain_count", 64'(q_a.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      checkLog($sformatf("burst_drain%0d", i), i, 24'(32'h10 + i), 8'(32'h11 + i));

    // Ordering across pointer wrap with random arbitrator latency
    $display("[TB] ordering and wrap");
    clearLog();
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, 24'(32'h100 + 3 * i), 8'(32'hC0 + 7 * i), 60, lat, q);
    waitIdle(400);
    checkOutput("order_count", 64'(q_a.size()), 64'd10);
    for (int i = 0; i < 10; i++)
      checkLog($sformatf("order%0d", i), i, 24'(32'h100 + 3 * i), 8'(32'hC0 + 7 * i));
    checkOutput("order_level", 64'(level), 64'd0);

`ifndef HRAM_WBUF_RAW_FWD_EN
    // Read waits for the queued write to drain
    $display("[TB] read after write");
    respEn = 1'b0;
    clearLog();
    s_q = 8'hA5;
    applyStimulus(1'b1, 24'h001234, 8'hA5, 5, lat, q);
    checkOutput("raw_wr_lat", 64'(lat), 64'd1);
    @(negedge clk);
    m_req = 1'b1;
    m_we  = 1'b0;
    m_a   = 24'h001234;
    m_d   = '0;
    seen  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (m_ack) seen = 1'b1;
    end
    checkOutput("raw_rd_held", 64'(seen), 64'd0);
    checkOutput("raw_rd_not_issued", {62'd0, s_req, s_we}, 64'd3);
    respRandom = 1'b0;
    respEn     = 1'b1;
    waitAck(20, lat);
    checkOutput("raw_m_q", 64'(m_q), 64'hA5);
    m_req = 1'b0;
    checkOutput("raw_log_count", 64'(q_a.size()), 64'd2);
    checkLog("raw_log_wr", 0, 24'h001234, 8'hA5);
    if (q_a.size() >= 2) begin
      checkOutput("raw_log_rd", {39'd0, q_we[1], q_a[1]}, {39'd0, 1'b0, 24'h001234});
      checkOutput("raw_rd_level", 64'(q_lvl[1]), 64'd0);
    end
    waitIdle(50);
`else
    // Read hits queued writes and is answered from the newest entry
    $display("[TB] forwarding");
    respEn = 1'b0;
    clearLog();
    applyStimulus(1'b1, 24'h001234, 8'hA5, 5, lat, q);
    checkOutput("fwd_wr0_lat", 64'(lat), 64'd1);
    applyStimulus(1'b1, 24'h001234, 8'h5A, 5, lat, q);
    checkOutput("fwd_wr1_lat", 64'(lat), 64'd1);
    applyStimulus(1'b0, 24'h001234, 8'h00, 5, lat, q);
    checkOutput("fwd_rd_lat", 64'(lat), 64'd1);
    checkOutput("fwd_rd_q", 64'(q), 64'h5A);
    @(negedge clk);
    checkOutput("fwd_no_downstream", 64'(q_a.size()), 64'd0);
    checkOutput("fwd_head_is_write", 64'(s_we), 64'd1);
    s_q   = 8'h3C;
    m_req = 1'b1;
    m_we  = 1'b0;
    m_a   = 24'h001235;
    seen  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (m_ack) seen = 1'b1;
    end
    checkOutput("fwd_miss_held", 64'(seen), 64'd0);
    respRandom = 1'b0;
    respEn     = 1'b1;
    waitAck(30, lat);
    checkOutput("fwd_miss_q", 64'(m_q), 64'h3C);
    m_req = 1'b0;
    checkOutput("fwd_miss_count", 64'(q_a.size()), 64'd3);
    if (q_a.size() >= 3)
      checkOutput("fwd_miss_rd", {39'd0, q_we[2], q_a[2]}, {39'd0, 1'b0, 24'h001235});
    waitIdle(50);
`endif

    // Master holds m_req through its ack cycle: only one push
    $display("[TB] no double accept");
    respEn = 1'b0;
    clearLog();
    @(negedge clk);
    m_req = 1'b1;
    m_we  = 1'b1;
    m_a   = 24'h002000;
    m_d   = 8'h77;
    @(negedge clk);
    checkOutput("nodbl_ack", 64'(m_ack), 64'd1);
    @(negedge clk);
    m_req = 1'b0;
    checkOutput("nodbl_level", 64'(level), 64'd1);
    checkOutput("nodbl_ack_gone", 64'(m_ack), 64'd0);
    checkOutput("nodbl_draining", 64'(s_req), 64'd1);

    // Asynchronous reset while a drain is in flight
    $display("[TB] reset mid-drain");
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_s_req", 64'(s_req), 64'd0);
    checkOutput("mid_rst_m_ack", 64'(m_ack), 64'd0);
    checkOutput("mid_rst_level", 64'(level), 64'd0);
    checkOutput("mid_rst_idle",  64'(idle),  64'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (s_req) seen = 1'b1;
    end
    checkOutput("post_rst_no_req", 64'(seen), 64'd0);
    checkOutput("post_rst_idle", 64'(idle), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hram_write_buffer.md
# hram_write_buffer

Posted-write buffer between the DMA engine's HyperRAM master port and one input of the HyperRAM memory arbitrator. It accepts byte writes at a fixed latency of one cycle and queues them in a small FIFO, then drains them to the arbitrator in order. Reads wait until all queued writes are committed, which keeps memory ordering intact. An `idle` flag tells the DMA engine when every posted write has landed in RAM, so it can raise its completion IRQ.

## Interface
- `ABITS`, 24: address width.
- `DBITS`, 8: data width.
- `DEPTH`, 4: number of FIFO entries; must be a power of two, at least 2.
- `clk` in 1: system clock (80 MHz `sysclk`).
- `reset_n` in 1: asynchronous, active-low reset.
- `m_req` in 1: master request, held until `m_ack`.
- `m_ack` out 1: one-cycle acknowledge to the master.
- `m_we` in 1: 1 = write, 0 = read.
- `m_a` in `ABITS`: master address.
- `m_d` in `DBITS`: master write data.
- `m_q` out `DBITS`: read data, valid while `m_ack`=1.
- `s_req` out 1: request to the arbitrator, held until `s_ack`.
- `s_ack` in 1: one-cycle acknowledge from the arbitrator.
- `s_we` out 1: write/read select to the arbitrator.
- `s_a` out `ABITS`: address to the arbitrator.
- `s_d` out `DBITS`: write data to the arbitrator.
- `s_q` in `DBITS`: read data from the arbitrator, valid with `s_ack`.
- `level` out `$clog2(DEPTH)+1`: number of queued writes.
- `idle` out 1: 1 when `level`=0, the drain engine is in IDLE and no read is outstanding.

## Operation
- **Handshake (both sides).** A request is held with stable `we`/`a`/`d` until its ack; ack is a single-cycle pulse. A new request is recognised only when `m_req`=1 and `m_ack`=0 in the same cycle, so a request is never accepted twice.
- **Master write.**
  - If `level` < `DEPTH`: store {a, d} at the write pointer, increment `level`, and pulse `m_ack`.
  - If the FIFO is full: stall with no ack. A pop in the same cycle does not admit a push; the push is accepted the cycle after.
- **Master read.**
  - Held until the FIFO is empty and the drain engine is in IDLE.
  - Then issued downstream: `s_q` is captured into `m_q` on `s_ack`, and `m_ack` is pulsed.
- **Drain engine states:**
  - IDLE → WR when `level`>0. Drive the head entry with `s_we`=1.
  - IDLE → RD when a read is pending and `level`=0. Drive `s_we`=0.
  - WR and RD return to IDLE on `s_ack`. In WR, `s_ack` also pops the head (read pointer +1, `level` -1).
  - Writes have priority over reads.
- **Counters and pointers.** Read and write pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. `level` counts 0..`DEPTH`. A push and a pop in the same cycle leave `level` unchanged.
- **Reset** (asynchronous, any state):
  - All queued writes are discarded and the engine returns to IDLE.
  - Reset values: `m_ack`=0, `m_q`=0, `s_req`=0, `s_we`=0, `s_a`=0, `s_d`=0, `level`=0, `idle`=1.

## Timing
- Write accept: `m_req` sampled at edge k → `m_ack` high during cycle k+1.
- Drain: `s_req` rises one cycle after an entry becomes head in IDLE. `s_req` falls the cycle after `s_ack` is sampled. Back-to-back entries leave a one-cycle gap in `s_req`.
- Read (no forwarding): `s_req` rises the cycle after the FIFO is empty and the engine is in IDLE. `m_ack` and `m_q` follow `s_ack` by one cycle.
- Outputs are registered. `idle` and `level` are registered and update on the same edge as the pointers.

## Configuration
- Macro: `HRAM_WBUF_RAW_FWD_EN`.
- **Defined:**
  - A read whose `m_a` matches any queued entry is answered from the buffer without draining.
  - The data comes from the newest matching entry.
  - `m_ack` is pulsed one cycle after the request is recognised, and no downstream read is issued.
  - A read that matches no entry behaves exactly as in the undefined case.
- **Undefined:** all reads wait for the FIFO to drain fully. No address comparators are built.

## Structure
- The shared package `super_reu_pkg` holds:
  - the drain-state encoding constants (IDLE, WR, RD);
  - the default `ABITS` and `DBITS` values used by the DMA engine, MMC64 and the arbitrator.
- One sub-module, `hram_wbuf_fifo`:
  - holds the entry storage, pointers and `level`;
  - ports: push, pop, full, empty, head data;
  - under the macro, also exports all entries plus a per-entry valid vector for the forwarding compare.
- Handshake logic and the drain FSM stay in `hram_write_buffer`.

## Test plan
- **Reset:** assert `reset_n`=0 mid-drain with `s_req`=1 → `s_req`, `m_ack` and `level` drop to 0 at once and `idle`=1. No `s_req` follows release.
- **Burst to full:** with `s_ack` held at 0, write 0x000010..0x000013 (data 0x11..0x14) → four `m_ack`s, each one cycle after its request, and `level`=4. The fifth write (0x000014) gets no ack until the first `s_ack`, then is acked one cycle after the pop.
- **Ordering and wrap:** 10 sequential writes, with `s_ack` returned randomly 1–5 cycles after `s_req` → downstream sees addresses and data in issue order across pointer wrap, then `idle`=1.
- **Read after writes (no macro):** write 0x001234=0xA5, then read 0x001234 → the downstream read is issued only after `level`=0. With `s_q`=0xA5, `m_q`=0xA5 on `m_ack`.
- **Forwarding (macro defined):**
  - Queue 0x001234=0xA5 then 0x001234=0x5A with `s_ack` stalled, then read 0x001234 → `m_ack` one cycle after the request is recognised, `m_q`=0x5A, no downstream read.
  - Read 0x001235 → waits for drain.
- **No double accept:** master holds `m_req` through the cycle where `m_ack`=1 → exactly one entry is pushed (`level` +1 only).
